cx_sched: RTL and testbench

- Round-robin scheduler that shares one cx custom-instruction unit among NREQ requesters (e.g. multiple bex cores or issue slots).
- Accepts one request at a time over per-requester valid/ready, drives the cx operand/opcode bus from registers, and captures the result, invalid and error flags.
- Returns a tagged response over a valid/ready channel.
- Guards against a non-responding unit with a timeout.

---
 rtl/cx_sched.sv | 196 +++++++++++++++++++
 tb/tb_cx_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cx_sched.sv
// cx_sched: round-robin arbiter that shares one cx custom-instruction unit
// among NREQ requesters. One request is in flight at a time: IDLE accepts,
// ISSUE drives the cx bus and waits for a result (bounded by TIMEOUT), and
// RESP holds a tagged response until the consumer takes it.
// Optional feature macro: CX_SCHED_STATS_EN adds the stat_ops / stat_errs
// counters.
module cx_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*10-1:0]  req_opcode,
  input  logic [NREQ*32-1:0]  req_op_a,
  input  logic [NREQ*32-1:0]  req_op_b,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [IDW-1:0]      resp_id,
  output logic [31:0]         resp_result,
  output logic                resp_invalid,
  output logic                resp_error,
  output logic                resp_timeout,
`ifdef CX_SCHED_STATS_EN
  output logic [31:0]         stat_ops,
  output logic [31:0]         stat_errs,
`endif
  output logic [9:0]          cx_opcode,
  output logic [31:0]         cx_op_a,
  output logic [31:0]         cx_op_b,
  input  logic                cx_invalid_opcode,
  input  logic [31:0]         cx_result,
  input  logic                cx_result_valid,
  input  logic                cx_result_error
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Last ISSUE cycle index before the forced timeout response.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   rr_ptr_r;
  logic [7:0]      tmo_cnt_r;
  logic [IDW-1:0]  id_r;

  logic            grant_found_s;
  logic [PW-1:0]   grant_idx_s;
  logic [PW-1:0]   scan_idx_s;
  logic [9:0]      sel_opcode_s;
  logic [31:0]     sel_op_a_s;
  logic [31:0]     sel_op_b_s;

  // Find the first valid requester starting at rr_ptr and wrapping around.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    scan_idx_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx_s = PW'((int'(rr_ptr_r) + k) % NREQ);
      if (!grant_found_s && req_valid[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Select the payload of the granted requester.
  always_comb begin
    sel_opcode_s = 10'd0;
    sel_op_a_s   = 32'd0;
    sel_op_b_s   = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == PW'(i)) begin
        sel_opcode_s = req_opcode[i*10 +: 10];
        sel_op_a_s   = req_op_a[i*32 +: 32];
        sel_op_b_s   = req_op_b[i*32 +: 32];
      end else begin
        sel_opcode_s = sel_opcode_s;
      end
    end
  end

  // Same-cycle accept for the granted requester; nothing is accepted in reset.
  always_comb begin
    req_ready = '0;
    if ((state_r == ST_IDLE) && !rst && grant_found_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Scheduler state machine with registered cx bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      tmo_cnt_r    <= 8'd0;
      id_r         <= '0;
      cx_opcode    <= 10'd0;
      cx_op_a      <= 32'd0;
      cx_op_b      <= 32'd0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_result  <= 32'd0;
      resp_invalid <= 1'b0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A found grant always handshakes: req_ready mirrors req_valid[g].
          if (grant_found_s) begin
            cx_opcode <= sel_opcode_s;
            cx_op_a   <= sel_op_a_s;
            cx_op_b   <= sel_op_b_s;
            id_r      <= IDW'(grant_idx_s);
            tmo_cnt_r <= 8'd0;
            state_r   <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cx_result_valid) begin
            resp_result  <= cx_result;
            resp_invalid <= cx_invalid_opcode;
            resp_error   <= cx_result_error;
            resp_timeout <= 1'b0;
            resp_id      <= id_r;
            resp_valid   <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
            if (tmo_cnt_r == TMO_LAST) begin
              resp_result  <= 32'd0;
              resp_invalid <= 1'b0;
              resp_error   <= 1'b1;
              resp_timeout <= 1'b1;
              resp_id      <= id_r;
              resp_valid   <= 1'b1;
              state_r      <= ST_RESP;
            end else begin
              state_r <= ST_ISSUE;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            // Last-served requester drops to lowest priority.
            rr_ptr_r   <= (id_r == IDW'(NREQ - 1)) ? '0 : PW'(id_r + IDW'(1));
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CX_SCHED_STATS_EN
  // Count completed responses and the subset that reported a problem.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops  <= 32'd0;
      stat_errs <= 32'd0;
    end else if (resp_valid && resp_ready) begin
      stat_ops <= stat_ops + 32'd1;
      if (resp_error || resp_invalid) begin
        stat_errs <= stat_errs + 32'd1;
      end else begin
        stat_errs <= stat_errs;
      end
    end else begin
      stat_ops  <= stat_ops;
      stat_errs <= stat_errs;
    end
  end
`endif

endmodule

// File: tb/tb_cx_sched.sv
// tb_cx_sched: self-checking bench for cx_sched. A small cx unit model answers
// the scheduler; a transaction-level reference model predicts grants, cx bus
// contents and responses every cycle. Directed scenarios are followed by a
// randomized phase. CX_SCHED_STATS_EN also enables counter checks.
module tb_cx_sched;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*10-1:0] req_opcode;
  logic [NREQ*32-1:0] req_op_a;
  logic [NREQ*32-1:0] req_op_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_result;
  logic               resp_invalid;
  logic               resp_error;
  logic               resp_timeout;
  logic [9:0]         cx_opcode;
  logic [31:0]        cx_op_a;
  logic [31:0]        cx_op_b;
  logic               cx_invalid_opcode;
  logic [31:0]        cx_result;
  logic               cx_vld;
  logic               cx_result_error;
`ifdef CX_SCHED_STATS_EN
  logic [31:0]        stat_ops;
  logic [31:0]        stat_errs;
`endif

  always #5 clk = ~clk;

  cx_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_invalid(resp_invalid),
    .resp_error(resp_error), .resp_timeout(resp_timeout),
`ifdef CX_SCHED_STATS_EN
    .stat_ops(stat_ops), .stat_errs(stat_errs),
`endif
    .cx_opcode(cx_opcode), .cx_op_a(cx_op_a), .cx_op_b(cx_op_b),
    .cx_invalid_opcode(cx_invalid_opcode), .cx_result(cx_result),
    .cx_result_valid(cx_vld), .cx_result_error(cx_result_error)
  );

  // cx unit behaviour: returns {invalid, error, result}.
  function automatic logic [33:0] cx_fn(input logic [9:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  bv;
    logic        inv;
    logic        err;
    r = 32'd0; inv = 1'b0; err = 1'b0;
    case (op)
      10'h001: begin
        for (int k = 0; k < 4; k++) begin
          bv = a[8*k +: 8];
          if (bv >= 8'h61 && bv <= 8'h7A) bv = bv - 8'h20;
          r[8*k +: 8] = bv;
        end
      end
      10'h002: r = a + b;
      10'h003: r = a ^ b;
      10'h008: begin
        if (a == 32'd0) err = 1'b1;
        for (int k = 0; k < 32; k++) if (a[k]) r = 32'(k);
      end
      default: inv = 1'b1;
    endcase
    return {inv, err, r};
  endfunction

  assign {cx_invalid_opcode, cx_result_error, cx_result} = cx_fn(cx_opcode, cx_op_a, cx_op_b);

  // Requester-side stimulus state.
  bit          pend [NREQ];
  logic [9:0]  p_opc [NREQ];
  logic [31:0] p_a [NREQ];
  logic [31:0] p_b [NREQ];
  int          auto_pct;
  int          cyc;
  int          gq_id[$];
  int          gq_cyc[$];

  // Reference model state (one job in flight at most).
  int          m_rr;
  bit          m_active, m_pending;
  int          m_waited, m_id;
  logic [9:0]  m_opc;
  logic [31:0] m_a, m_b;
  logic [31:0] e_result;
  logic        e_inv, e_err, e_to;
  logic [31:0] m_ops, m_errs;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  task automatic new_req(input int i);
    int sel;
    sel = $urandom_range(5);
    case (sel)
      0: p_opc[i] = 10'h001;
      1: p_opc[i] = 10'h002;
      2: p_opc[i] = 10'h003;
      3: p_opc[i] = 10'h008;
      4: p_opc[i] = 10'h3FF;
      default: p_opc[i] = 10'($urandom);
    endcase
    p_a[i] = $urandom;
    p_b[i] = $urandom;
    if (p_opc[i] == 10'h008 && $urandom_range(3) == 0) p_a[i] = 32'd0;
    pend[i] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_opcode[i*10 +: 10] = pend[i] ? p_opc[i] : 10'($urandom);
      req_op_a[i*32 +: 32]   = pend[i] ? p_a[i] : 32'($urandom);
      req_op_b[i*32 +: 32]   = pend[i] ? p_b[i] : 32'($urandom);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_active = 1'b0; m_pending = 1'b0; m_waited = 0;
    m_ops = 32'd0; m_errs = 32'd0;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_rdy;
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && auto_pct > 0 && $urandom_range(99) < auto_pct) new_req(i);
    drive();
    #1;
    g = pick(req_valid, m_rr);
    exp_rdy = '0;
    if (!rst && !m_active && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i] === 1'b1) begin gq_id.push_back(i); gq_cyc.push_back(cyc); end
    chk("resp_valid", 64'(resp_valid), 64'(m_pending));
    if (m_pending) begin
      chk("resp_id", 64'(resp_id), 64'(m_id));
      chk("resp_result", 64'(resp_result), 64'(e_result));
      chk("resp_invalid", 64'(resp_invalid), 64'(e_inv));
      chk("resp_error", 64'(resp_error), 64'(e_err));
      chk("resp_timeout", 64'(resp_timeout), 64'(e_to));
    end
    if (m_active) begin
      chk("cx_opcode", 64'(cx_opcode), 64'(m_opc));
      chk("cx_op_a", 64'(cx_op_a), 64'(m_a));
      chk("cx_op_b", 64'(cx_op_b), 64'(m_b));
    end
`ifdef CX_SCHED_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'(m_ops));
    chk("stat_errs", 64'(stat_errs), 64'(m_errs));
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_pending) begin
      if (resp_ready) begin
        m_ops++;
        if (e_err || e_inv) m_errs++;
        m_active = 1'b0; m_pending = 1'b0;
        m_rr = (m_id + 1) % NREQ;
      end
    end else if (m_active) begin
      m_waited++;
      if (cx_vld) begin
        {e_inv, e_err, e_result} = cx_fn(m_opc, m_a, m_b);
        e_to = 1'b0; m_pending = 1'b1;
      end else if (m_waited == TIMEOUT) begin
        e_result = 32'd0; e_inv = 1'b0; e_err = 1'b1; e_to = 1'b1;
        m_pending = 1'b1;
      end
    end else if (g >= 0) begin
      m_active = 1'b1; m_waited = 0; m_id = g;
      m_opc = p_opc[g]; m_a = p_a[g]; m_b = p_b[g];
      pend[g] = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int rr0;
    n_cmp = 0; n_err = 0; cyc = 0; auto_pct = 0;
    rst = 1'b1; cx_vld = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    model_reset();
    drive();
    // Reset state: nothing accepted while rst is high, all outputs cleared.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_fields", {resp_id, resp_invalid, resp_error, resp_timeout}, 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_cx_opcode", 64'(cx_opcode), 64'd0);
    chk("rst_cx_ops", {cx_op_a, cx_op_b}, 64'd0);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single request: toupper of "ab".
    pend[0] = 1'b1; p_opc[0] = 10'h001; p_a[0] = 32'h0000_6162; p_b[0] = 32'd0;
    drive(); #1;
    chk("tp1_ready", 64'(req_ready), 64'b0001);
    step(); step();
    #1;
    chk("tp1_resp_valid", 64'(resp_valid), 64'd1);
    chk("tp1_resp_id", 64'(resp_id), 64'd0);
    chk("tp1_resp_result", 64'(resp_result), 64'h4142);
    chk("tp1_flags", {resp_error, resp_invalid}, 64'd0);
    step(); step();

    // Round robin with every requester continuously valid.
    rr0 = m_rr;
    gq_id.delete(); gq_cyc.delete();
    auto_pct = 100;
    repeat (15) step();
    auto_pct = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < gq_id.size()) chk("rr_order", 64'(gq_id[k]), 64'((rr0 + k) % NREQ));
      else chk("rr_missing_grant", 64'(gq_id.size()), 64'(5));
      if (k > 0 && k < gq_cyc.size()) chk("rr_spacing", 64'(gq_cyc[k] - gq_cyc[k-1]), 64'd3);
    end
    repeat (16) step();

    // Backpressure: response held, nothing else accepted, next accept right after.
    pend[1] = 1'b1; p_opc[1] = 10'h002; p_a[1] = $urandom; p_b[1] = $urandom;
    resp_ready = 1'b0;
    step(); step();
    pend[0] = 1'b1; pend[2] = 1'b1; pend[3] = 1'b1;
    repeat (6) step();
    resp_ready = 1'b1;
    step();
    drive(); #1;
    chk("bp_next_accept", 64'(req_ready != '0), 64'd1);
    repeat (12) step();

    // Invalid opcode, then most-significant-one on 0x10000.
    pend[2] = 1'b1; p_opc[2] = 10'h3FF; p_a[2] = $urandom; p_b[2] = $urandom;
    step(); step(); #1;
    chk("inv_flag", 64'(resp_invalid), 64'd1);
    step(); step();
    pend[3] = 1'b1; p_opc[3] = 10'h008; p_a[3] = 32'h0001_0000; p_b[3] = 32'd0;
    step(); step(); #1;
    chk("ms1b_result", 64'(resp_result), 64'd16);
    chk("ms1b_error", 64'(resp_error), 64'd0);
    step(); step();

    // Timeout: cx never answers.
    cx_vld = 1'b0;
    pend[0] = 1'b1; p_opc[0] = 10'h002; p_a[0] = $urandom; p_b[0] = $urandom;
    repeat (15) step();
    #1;
    chk("tmo_not_yet", 64'(resp_valid), 64'd0);
    step(); #1;
    chk("tmo_valid", 64'(resp_valid), 64'd1);
    chk("tmo_flags", {resp_error, resp_timeout}, 64'b11);
    chk("tmo_result", 64'(resp_result), 64'd0);
    cx_vld = 1'b1;
    step(); step();

    // Reset in the middle of ISSUE drops the job and rewinds rr_ptr.
    cx_vld = 1'b0;
    pend[1] = 1'b1; p_opc[1] = 10'h003; p_a[1] = $urandom; p_b[1] = $urandom;
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0; cx_vld = 1'b1;
    repeat (3) step();
    #1;
    chk("rst_mid_no_resp", 64'(resp_valid), 64'd0);
    pend[2] = 1'b1; p_opc[2] = 10'h002; p_a[2] = $urandom; p_b[2] = $urandom;
    pend[3] = 1'b1; p_opc[3] = 10'h001; p_a[3] = $urandom; p_b[3] = $urandom;
    drive(); #1;
    chk("rst_mid_grant", 64'(req_ready), 64'b0100);
    step(); step(); #1;
    chk("rst_mid_resp_id", 64'(resp_id), 64'd2);
    repeat (8) step();

    // Randomized traffic with dead-cx stretches and occasional resets.
    auto_pct = 30;
    for (int c = 0; c < 1500; c++) begin
      cx_vld = ((c % 400) >= 200 && (c % 400) < 260) ? 1'b0 : ($urandom_range(99) < 75);
      resp_ready = ($urandom_range(99) < 65);
      rst = ($urandom_range(299) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
